// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and lane helper for the camera input front end.
package cam_pkg;

  localparam int unsigned PIXEL_WIDTH_DEF = 8;
  localparam int unsigned NUM_CH_DEF      = 2;
  localparam int unsigned X_WIDTH_DEF     = 11;
  localparam int unsigned Y_WIDTH_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    IN_FRAME
  } cam_state_t;

  // LSB position of lane k in a packed multi-lane pixel bus.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Rising/falling edge detector against a registered copy of the input.
module cam_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/cam_input_frontend.sv
// Two-stage camera input register with X/Y tracking, boundary strobes and line-length check.
// Optional region-of-interest gating when CAM_ROI_CROP_EN is defined.
module cam_input_frontend
  import cam_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned X_WIDTH     = X_WIDTH_DEF,
  parameter int unsigned Y_WIDTH     = Y_WIDTH_DEF
`ifdef CAM_ROI_CROP_EN
  ,
  parameter int unsigned ROI_X0      = 2,
  parameter int unsigned ROI_Y0      = 1,
  parameter int unsigned ROI_W       = 3,
  parameter int unsigned ROI_H       = 2
`endif
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          iLVAL,
  input  logic                          iFVAL,
  input  logic                          iDVAL,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] iDATA,
  output logic                          oLVAL,
  output logic                          oFVAL,
  output logic                          oDVAL,
  output logic [NUM_CH*PIXEL_WIDTH-1:0] oDATA,
  output logic [X_WIDTH-1:0]            oX,
  output logic [Y_WIDTH-1:0]            oY,
  output logic                          oSOF,
  output logic                          oEOL,
  output logic                          oEOF,
  output logic [X_WIDTH-1:0]            oLINE_LEN,
  output logic                          oLINE_ERR
);

  localparam int unsigned DW = NUM_CH * PIXEL_WIDTH;

  logic          s1_lval, s1_fval, s1_dval, s1_primed;
  logic [DW-1:0] s1_data;

  logic lval_rise, lval_fall, fval_rise, fval_fall;

  cam_state_t state;

  logic [X_WIDTH-1:0] x_cnt, cur_x, x_out;
  logic [Y_WIDTH-1:0] y_cnt, cur_y, y_out;
  logic               first_line, sof_pend;
  logic               in_frame, frame_start, active, accept, pix_out;
  logic               eol_ev, eof_ev;

  // Stage 1: plain input register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_lval   <= 1'b0;
      s1_fval   <= 1'b0;
      s1_dval   <= 1'b0;
      s1_data   <= '0;
      s1_primed <= 1'b0;
    end else begin
      s1_lval   <= iLVAL;
      s1_fval   <= iFVAL;
      s1_dval   <= iDVAL;
      s1_data   <= iDATA;
      s1_primed <= 1'b1;
    end
  end

  cam_edge_det u_lval_edge (
    .CLK  (CLK),
    .RST  (RST),
    .sig  (s1_lval),
    .rise (lval_rise),
    .fall (lval_fall)
  );

  cam_edge_det u_fval_edge (
    .CLK  (CLK),
    .RST  (RST),
    .sig  (s1_fval),
    .rise (fval_rise),
    .fall (fval_fall)
  );

`ifdef CAM_ROI_CROP_EN
  localparam logic [X_WIDTH:0] RX0 = (X_WIDTH+1)'(ROI_X0);
  localparam logic [X_WIDTH:0] RX1 = (X_WIDTH+1)'(ROI_X0 + ROI_W);
  localparam logic [Y_WIDTH:0] RY0 = (Y_WIDTH+1)'(ROI_Y0);
  localparam logic [Y_WIDTH:0] RY1 = (Y_WIDTH+1)'(ROI_Y0 + ROI_H);
  logic in_roi;
`endif

  always_comb begin
    in_frame    = (state == IN_FRAME);
    frame_start = (state == WAIT_FRAME) & fval_rise;
    active      = in_frame | frame_start;
    accept      = active & s1_fval & s1_lval & s1_dval;
    eol_ev      = in_frame & lval_fall;
    eof_ev      = in_frame & fval_fall;
    // A pixel landing on the same cycle as a line/frame start must see a cleared counter.
    cur_x       = lval_rise   ? '0 : x_cnt;
    cur_y       = frame_start ? '0 : y_cnt;
`ifdef CAM_ROI_CROP_EN
    in_roi  = ({1'b0, cur_x} >= RX0) && ({1'b0, cur_x} < RX1) &&
              ({1'b0, cur_y} >= RY0) && ({1'b0, cur_y} < RY1);
    pix_out = accept & in_roi;
    x_out   = cur_x - RX0[X_WIDTH-1:0];
    y_out   = cur_y - RY0[Y_WIDTH-1:0];
`else
    pix_out = accept;
    x_out   = cur_x;
    y_out   = cur_y;
`endif
  end

  // Frame FSM, counters, line-length check and stage-2 output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      first_line <= 1'b0;
      sof_pend   <= 1'b0;
      oLINE_LEN  <= '0;
      oLINE_ERR  <= 1'b0;
      oLVAL      <= 1'b0;
      oFVAL      <= 1'b0;
      oDVAL      <= 1'b0;
      oDATA      <= '0;
      oX         <= '0;
      oY         <= '0;
      oSOF       <= 1'b0;
      oEOL       <= 1'b0;
      oEOF       <= 1'b0;
    end else begin
      case (state)
        // Only leave IDLE once a real stage-1 sample shows FVAL low.
        IDLE: begin
          if (s1_primed && !s1_fval) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (fval_rise) begin
            state      <= IN_FRAME;
            oLINE_ERR  <= 1'b0;
            first_line <= 1'b1;
          end
        end
        IN_FRAME: begin
          if (fval_fall) state <= WAIT_FRAME;
        end
        default: state <= IDLE;
      endcase

      if (!active || lval_fall) begin
        x_cnt <= '0;
      end else if (accept) begin
        x_cnt <= (cur_x == '1) ? cur_x : cur_x + X_WIDTH'(1);
      end else begin
        x_cnt <= cur_x;
      end

      if (frame_start) begin
        y_cnt <= '0;
      end else if (eol_ev) begin
        y_cnt <= (y_cnt == '1) ? y_cnt : y_cnt + Y_WIDTH'(1);
      end

      if (eol_ev) begin
        if (first_line) begin
          oLINE_LEN  <= x_cnt;
          first_line <= 1'b0;
        end else if (x_cnt != oLINE_LEN) begin
          oLINE_ERR <= 1'b1;
        end
      end

      if (frame_start) begin
        sof_pend <= ~pix_out;
      end else if (pix_out) begin
        sof_pend <= 1'b0;
      end

      oLVAL <= s1_lval;
      oFVAL <= s1_fval;
      oDVAL <= pix_out;
      oSOF  <= pix_out & (frame_start | sof_pend);
      oEOL  <= eol_ev;
      oEOF  <= eof_ev;
      if (pix_out) begin
        oX <= x_out;
        oY <= y_out;
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        oDATA[lane_lsb(k, PIXEL_WIDTH) +: PIXEL_WIDTH] <= s1_data[lane_lsb(k, PIXEL_WIDTH) +: PIXEL_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cam_input_frontend.sv
// Scoreboard bench for cam_input_frontend; define CAM_ROI_CROP_EN to exercise the ROI build.
module tb_cam_input_frontend;

  localparam int unsigned PW  = 8;
  localparam int unsigned NCH = 2;
  localparam int unsigned XW  = 11;
  localparam int unsigned YW  = 10;
`ifdef CAM_ROI_CROP_EN
  localparam int RX0 = 2;
  localparam int RY0 = 1;
  localparam int RW  = 3;
  localparam int RH  = 2;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              iLVAL = 1'b0, iFVAL = 1'b0, iDVAL = 1'b0;
  logic [NCH*PW-1:0] iDATA = '0;
  logic              oLVAL, oFVAL, oDVAL, oSOF, oEOL, oEOF, oLINE_ERR;
  logic [NCH*PW-1:0] oDATA;
  logic [XW-1:0]     oX, oLINE_LEN;
  logic [YW-1:0]     oY;

  cam_input_frontend #(
    .PIXEL_WIDTH (PW),
    .NUM_CH      (NCH),
    .X_WIDTH     (XW),
    .Y_WIDTH     (YW)
`ifdef CAM_ROI_CROP_EN
    ,
    .ROI_X0      (RX0),
    .ROI_Y0      (RY0),
    .ROI_W       (RW),
    .ROI_H       (RH)
`endif
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iLVAL     (iLVAL),
    .iFVAL     (iFVAL),
    .iDVAL     (iDVAL),
    .iDATA     (iDATA),
    .oLVAL     (oLVAL),
    .oFVAL     (oFVAL),
    .oDVAL     (oDVAL),
    .oDATA     (oDATA),
    .oX        (oX),
    .oY        (oY),
    .oSOF      (oSOF),
    .oEOL      (oEOL),
    .oEOF      (oEOF),
    .oLINE_LEN (oLINE_LEN),
    .oLINE_ERR (oLINE_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [NCH*PW-1:0] d;
    logic              sof;
    int                cyc;
  } pix_t;

  pix_t          exp_q[$];
  pix_t          obs_q[$];
  logic          eol_err_q[$];
  int            eol_cnt, eof_cnt, both_cnt, stray_sof;
  logic          eof_err;
  logic [XW-1:0] eof_len;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            exp_sof_pend;
  bit            gp[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Output collector: records events only, comparisons happen in the test tasks.
  always @(negedge CLK) begin
    if (oDVAL) obs_q.push_back('{x: oX, y: oY, d: oDATA, sof: oSOF, cyc: cyc});
    if (oSOF && !oDVAL) stray_sof++;
    if (oEOL) begin
      eol_cnt++;
      eol_err_q.push_back(oLINE_ERR);
    end
    if (oEOF) begin
      eof_cnt++;
      eof_err = oLINE_ERR;
      eof_len = oLINE_LEN;
    end
    if (oEOL && oEOF) both_cnt++;
  end

  task automatic drive(input logic lv, input logic fv, input logic dv, input logic [NCH*PW-1:0] d);
    @(negedge CLK);
    iLVAL = lv;
    iFVAL = fv;
    iDVAL = dv;
    iDATA = d;
  endtask

  task automatic clr_mon();
    #2;
    obs_q.delete();
    exp_q.delete();
    eol_err_q.delete();
    eol_cnt   = 0;
    eof_cnt   = 0;
    both_cnt  = 0;
    stray_sof = 0;
    eof_err   = 1'bx;
    eof_len   = 'x;
  endtask

  task automatic push_exp(input int x, input int y, input logic [NCH*PW-1:0] d, input int c);
    int ex, ey;
    ex = x;
    ey = y;
`ifdef CAM_ROI_CROP_EN
    if (ex < RX0 || ex >= RX0 + RW || ey < RY0 || ey >= RY0 + RH) return;
    ex = ex - RX0;
    ey = ey - RY0;
`endif
    exp_q.push_back('{x: XW'(ex), y: YW'(ey), d: d, sof: exp_sof_pend, cyc: c + 2});
    exp_sof_pend = 1'b0;
  endtask

  task automatic send_frame(input int nl, input int len, input int short_idx, input int short_len,
                            input bit gaps, input bit simul, input bit exp_on);
    int         n, bx;
    bit         dv;
    logic [7:0] xb;
    exp_sof_pend = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int l = 0; l < nl; l++) begin
      n  = gaps ? 6 : ((l == short_idx) ? short_len : len);
      bx = 0;
      for (int i = 0; i < n; i++) begin
        dv = gaps ? gp[i] : 1'b1;
        xb = 8'(bx);
        if (dv) begin
          drive(1'b1, 1'b1, 1'b1, {~xb, xb});
          if (exp_on) push_exp(bx, l, {~xb, xb}, cyc);
          bx++;
        end else begin
          drive(1'b1, 1'b1, 1'b0, 16'h5555);
        end
      end
      if (simul && l == nl - 1) begin
        drive(1'b0, 1'b0, 1'b0, '0);
      end else begin
        drive(1'b0, 1'b1, 1'b1, 16'hAAAA);
        drive(1'b0, 1'b1, 1'b0, '0);
      end
    end
    if (!simul) drive(1'b0, 1'b0, 1'b0, '0);
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
    #2;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if ({oLVAL, oFVAL, oDVAL, oSOF, oEOL, oEOF, oLINE_ERR} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000000", {oLVAL, oFVAL, oDVAL, oSOF, oEOL, oEOF, oLINE_ERR});
    end
    n_cmp++;
    if (oDATA !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", oDATA); end
    n_cmp++;
    if (oX !== '0 || oY !== '0) begin n_err++; $display("FAIL reset_xy got %0d,%0d want 0,0", oX, oY); end
    n_cmp++;
    if (oLINE_LEN !== '0) begin n_err++; $display("FAIL reset_len got %0d want 0", oLINE_LEN); end
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_outside();
    clr_mon();
    repeat (5) drive(1'b1, 1'b0, 1'b1, 16'h1234);
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
    #2;
    n_cmp++;
    if (obs_q.size() != 0 || eol_cnt + eof_cnt + stray_sof != 0) begin
      n_err++;
      $display("FAIL outside_activity got pix=%0d eol=%0d eof=%0d sof=%0d want all 0",
               obs_q.size(), eol_cnt, eof_cnt, stray_sof);
    end
  endtask

  task automatic test_basic_frame();
    pix_t o, e;
    clr_mon();
    send_frame(4, 8, -1, 0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.x !== e.x || o.y !== e.y || o.d !== e.d || o.sof !== e.sof || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL basic_pix got x=%0d y=%0d d=%h sof=%b cyc=%0d want x=%0d y=%0d d=%h sof=%b cyc=%0d",
                 o.x, o.y, o.d, o.sof, o.cyc, e.x, e.y, e.d, e.sof, e.cyc);
      end
    end
    n_cmp++;
    if (eol_cnt != 4) begin n_err++; $display("FAIL basic_eol got %0d want 4", eol_cnt); end
    n_cmp++;
    if (eof_cnt != 1) begin n_err++; $display("FAIL basic_eof got %0d want 1", eof_cnt); end
    n_cmp++;
    if (eof_len !== 11'd8) begin n_err++; $display("FAIL basic_len got %0d want 8", eof_len); end
    n_cmp++;
    if (eof_err !== 1'b0) begin n_err++; $display("FAIL basic_err got %b want 0", eof_err); end
    n_cmp++;
    if (stray_sof != 0) begin n_err++; $display("FAIL basic_stray_sof got %0d want 0", stray_sof); end
  endtask

  task automatic test_line_err();
    logic want;
    clr_mon();
    send_frame(4, 8, 1, 7, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (eol_err_q.size() != 4) begin
      n_err++; $display("FAIL lerr_eols got %0d want 4", eol_err_q.size());
    end
    for (int i = 0; i < 4 && i < eol_err_q.size(); i++) begin
      want = (i >= 1);
      n_cmp++;
      if (eol_err_q[i] !== want) begin
        n_err++; $display("FAIL lerr_line%0d got %b want %b", i, eol_err_q[i], want);
      end
    end
    n_cmp++;
    if (eof_err !== 1'b1) begin n_err++; $display("FAIL lerr_at_eof got %b want 1", eof_err); end
    n_cmp++;
    if (eof_len !== 11'd8) begin n_err++; $display("FAIL lerr_len got %0d want 8", eof_len); end
    clr_mon();
    send_frame(3, 8, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (eol_err_q.size() == 0 || eol_err_q[0] !== 1'b0) begin
      n_err++; $display("FAIL lerr_clear got n=%0d want first eol err=0", eol_err_q.size());
    end
    n_cmp++;
    if (eof_err !== 1'b0) begin n_err++; $display("FAIL lerr_clear_eof got %b want 0", eof_err); end
  endtask

  task automatic test_dval_gaps();
    pix_t o, e;
    clr_mon();
    send_frame(2, 0, -1, 0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL gaps_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.x !== e.x || o.y !== e.y || o.d !== e.d || o.sof !== e.sof || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL gaps_pix got x=%0d y=%0d d=%h sof=%b cyc=%0d want x=%0d y=%0d d=%h sof=%b cyc=%0d",
                 o.x, o.y, o.d, o.sof, o.cyc, e.x, e.y, e.d, e.sof, e.cyc);
      end
    end
    n_cmp++;
    if (eof_len !== 11'd4) begin n_err++; $display("FAIL gaps_len got %0d want 4", eof_len); end
    n_cmp++;
    if (eof_err !== 1'b0) begin n_err++; $display("FAIL gaps_err got %b want 0", eof_err); end
  endtask

  task automatic test_reset_midline();
    pix_t o, e;
    clr_mon();
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 16'h0F0F);
    #2;
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({oDVAL, oSOF, oEOL, oEOF, oLINE_ERR} !== 5'b0 || oX !== '0 || oLINE_LEN !== '0) begin
      n_err++;
      $display("FAIL rstmid_async got flags=%b x=%0d len=%0d want 0", {oDVAL, oSOF, oEOL, oEOF, oLINE_ERR}, oX, oLINE_LEN);
    end
    drive(1'b1, 1'b1, 1'b1, 16'h0F0F);
    drive(1'b1, 1'b1, 1'b1, 16'h0F0F);
    drive(1'b1, 1'b1, 1'b1, 16'h0F0F);
    RST = 1'b0;
    clr_mon();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 16'h0F0F);
    repeat (2) drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 16'h0F0F);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    #2;
    n_cmp++;
    if (obs_q.size() != 0 || eol_cnt + eof_cnt + stray_sof != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet got pix=%0d eol=%0d eof=%0d sof=%0d want all 0",
               obs_q.size(), eol_cnt, eof_cnt, stray_sof);
    end
    clr_mon();
    send_frame(2, 8, -1, 0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.x !== e.x || o.y !== e.y || o.d !== e.d || o.sof !== e.sof || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL rstmid_pix got x=%0d y=%0d sof=%b cyc=%0d want x=%0d y=%0d sof=%b cyc=%0d",
                 o.x, o.y, o.sof, o.cyc, e.x, e.y, e.sof, e.cyc);
      end
    end
    n_cmp++;
    if (eol_cnt != 2 || eof_cnt != 1) begin
      n_err++; $display("FAIL rstmid_strobes got eol=%0d eof=%0d want 2,1", eol_cnt, eof_cnt);
    end
  endtask

  task automatic test_simul_fall();
    clr_mon();
    send_frame(3, 5, -1, 0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (eol_cnt != 3 || eof_cnt != 1) begin
      n_err++; $display("FAIL simul_counts got eol=%0d eof=%0d want 3,1", eol_cnt, eof_cnt);
    end
    n_cmp++;
    if (both_cnt != 1) begin n_err++; $display("FAIL simul_same_cycle got %0d want 1", both_cnt); end
    n_cmp++;
    if (obs_q.size() == 0 || exp_q.size() == 0 || obs_q[$].y !== exp_q[$].y) begin
      n_err++;
      $display("FAIL simul_last_y got n=%0d want final y from %0d expected pixels", obs_q.size(), exp_q.size());
    end
    n_cmp++;
    if (eof_len !== 11'd5) begin n_err++; $display("FAIL simul_len got %0d want 5", eof_len); end
  endtask

`ifdef CAM_ROI_CROP_EN
  task automatic test_roi();
    pix_t o, e;
    clr_mon();
    send_frame(4, 8, -1, 0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_q.size() != 6) begin n_err++; $display("FAIL roi_count got %0d want 6", obs_q.size()); end
    n_cmp++;
    if (obs_q.size() == 0 || obs_q[0].x !== '0 || obs_q[0].y !== '0 || obs_q[0].sof !== 1'b1) begin
      n_err++; $display("FAIL roi_sof got n=%0d want first pixel sof at (0,0)", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.x !== e.x || o.y !== e.y || o.d !== e.d || o.sof !== e.sof || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL roi_pix got x=%0d y=%0d sof=%b want x=%0d y=%0d sof=%b", o.x, o.y, o.sof, e.x, e.y, e.sof);
      end
    end
    n_cmp++;
    if (eol_cnt != 4 || eof_len !== 11'd8) begin
      n_err++; $display("FAIL roi_fullframe got eol=%0d len=%0d want 4,8", eol_cnt, eof_len);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_outside();
    test_basic_frame();
    test_line_err();
    test_dval_gaps();
    test_reset_midline();
    test_simul_fall();
`ifdef CAM_ROI_CROP_EN
    test_roi();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cam_input_frontend.md
Name: cam_input_frontend

Overview:
- Multi-channel successor to the stereo camera input register. Registers NUM_CH pixel lanes plus LVAL/FVAL/DVAL from the sensor interface and tracks pixel position (X/Y).
- Emits frame and line boundary strobes and checks line-length consistency within a frame.
- Sits between the camera pins and the pupil-detection pipeline; downstream blocks consume position-tagged pixels.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel per channel
- NUM_CH, 2, number of parallel pixel lanes (2 = stereo L/R)
- X_WIDTH, 11, width of column counter (max 2047 pixels/line)
- Y_WIDTH, 10, width of row counter (max 1023 lines/frame)

Ports:
- CLK  in  1  pixel clock
- RST  in  1  asynchronous reset, active-high
- iLVAL  in  1  line valid
- iFVAL  in  1  frame valid
- iDVAL  in  1  data valid
- iDATA  in  NUM_CH*PIXEL_WIDTH  pixel lanes; lane k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]
- oLVAL / oFVAL / oDVAL  out  1  registered, aligned qualifiers
- oDATA  out  NUM_CH*PIXEL_WIDTH  aligned pixel lanes
- oX  out  X_WIDTH  column index of current oDATA
- oY  out  Y_WIDTH  row index of current oDATA
- oSOF  out  1  one-cycle strobe with first valid pixel of a frame
- oEOL  out  1  one-cycle strobe, cycle after the LVAL falling edge
- oEOF  out  1  one-cycle strobe, cycle after the FVAL falling edge
- oLINE_LEN  out  X_WIDTH  pixel count of the first line of the current frame
- oLINE_ERR  out  1  sticky per frame: a line length differed from oLINE_LEN

Behaviour:
- Reset: every output is 0, counters are 0, and the FSM is in IDLE. Reset is asynchronous and is honoured mid-frame; the first frame after reset starts at the next FVAL rising edge.
- Stage 1 registers all inputs. Stage 2 registers data and qualifiers and appends oX/oY/strobes.
- Total latency is 2 cycles from input to oDATA/oDVAL. Strobes align with the pixel or edge they describe at output timing.
- Pixel accepted = stage-1 FVAL & LVAL & DVAL. A pixel with DVAL=1 outside LVAL or FVAL is dropped: oDVAL=0.
- FSM states:
  - IDLE: wait for FVAL=0. This discards any partial frame in progress at reset.
  - WAIT_FRAME: FVAL rise goes to IN_FRAME; Y and LINE_ERR clear.
  - IN_FRAME: counts pixels and lines; FVAL fall goes to WAIT_FRAME.
- X counter:
  - Increments per accepted pixel; oX is the pre-increment value, so the first pixel of a line has oX=0.
  - Clears at LVAL falling edge.
  - Saturates at all-ones; no wrap.
- Y counter:
  - Increments at each LVAL falling edge within the frame.
  - Clears at FVAL rising edge.
  - Saturates at all-ones.
- oSOF: first accepted pixel after entering IN_FRAME, only once per frame.
- Line length:
  - At the first LVAL fall in a frame, the final X count loads oLINE_LEN.
  - Each later LVAL fall compares its count to oLINE_LEN and sets oLINE_ERR on mismatch.
  - A line with zero accepted pixels counts as length 0 and is compared the same way.
  - oLINE_ERR holds through oEOF and clears on the next FVAL rise.
- Simultaneous LVAL fall and FVAL fall: oEOL and oEOF both pulse in the same cycle, and Y increments before the frame ends.
- LVAL high while FVAL low: ignored, with no counter or strobe activity.

Optional Feature:
- Macro: CAM_ROI_CROP_EN.
- When defined: adds parameters ROI_X0, ROI_Y0, ROI_W, ROI_H, which must be nonzero.
  - oDVAL is asserted only for pixels with ROI_X0 <= X < ROI_X0+ROI_W and ROI_Y0 <= Y < ROI_Y0+ROI_H.
  - oX/oY report coordinates relative to (ROI_X0, ROI_Y0).
  - oSOF marks the first in-window pixel.
  - oLVAL/oFVAL, line-length check and oEOL/oEOF remain full-frame.
- When undefined: no gating and absolute coordinates; the ROI parameters do not exist.

Decomposition:
- Shared package cam_pkg holds:
  - default PIXEL_WIDTH, X_WIDTH, Y_WIDTH constants
  - FSM state typedef (IDLE, WAIT_FRAME, IN_FRAME)
  - lane-slice helper function
- One natural sub-module, cam_edge_det: registered rising/falling edge detector, instantiated for LVAL and FVAL.

Test Plan:
- Reset then a 4-line x 8-pixel frame, NUM_CH=2, lane0=X, lane1=~X → oX 0..7, oY 0..3. oSOF with (0,0). 4 oEOL, 1 oEOF. oLINE_LEN=8, oLINE_ERR=0. Data appears 2 cycles after input.
- Frame whose line 2 has 7 pixels → oLINE_ERR rises after line 2 ends and stays set through oEOF. The next well-formed frame clears it at FVAL rise.
- DVAL gaps inside a line (pattern 1,0,1,1,0,1) → oX increments only on valid pixels (0,1,2,3). oDVAL mirrors the gaps.
- Assert RST mid-line, release with FVAL=1 → no strobes or oDVAL until FVAL falls and rises again. The following frame starts at oY=0.
- Simultaneous LVAL/FVAL fall on the last line → oEOL and oEOF high in the same cycle, and the final oY equals line count-1.
- CAM_ROI_CROP_EN, ROI=(2,1,3,2) on an 8x4 frame → exactly 6 oDVAL pixels, oX 0..2, oY 0..1, and oSOF on relative (0,0).
